// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit RISC core: opcodes, pc_op encoding,
// sequencer state codes, ccr bit positions and instruction classification.
package cpu_pkg;

  localparam logic [3:0] OP_SYS = 4'h0;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZE = 4'h9;
  localparam logic [3:0] OP_JNE = 4'hA;
  localparam logic [3:0] OP_JCY = 4'hB;
  localparam logic [3:0] OP_MER = 4'hC;
  localparam logic [3:0] OP_MEW = 4'hD;
  localparam logic [3:0] OP_BSR = 4'hE;

  localparam logic [3:0] SUB_RET = 4'hD;
  localparam logic [3:0] SUB_HLT = 4'hF;

  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_C = 0;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_JUMP = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_op_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_COND   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_JMP, CL_JZE, CL_JNE, CL_JCY,
    CL_MER, CL_MEW, CL_BSR, CL_RET, CL_HLT
  } op_class_t;

  function automatic op_class_t classify(input logic [7:0] op);
    op_class_t c;
    c = CL_ALU;
    case (op[7:4])
      OP_SYS: begin
        if (op[3:0] == SUB_RET) c = CL_RET;
        else if (op[3:0] == SUB_HLT) c = CL_HLT;
      end
      OP_JMP: c = CL_JMP;
      OP_JZE: c = CL_JZE;
      OP_JNE: c = CL_JNE;
      OP_JCY: c = CL_JCY;
      OP_MER: c = CL_MER;
      OP_MEW: c = CL_MEW;
      OP_BSR: c = CL_BSR;
      default: c = CL_ALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; timeout flags the WAIT_MAX-th one.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && !timeout) cnt <= cnt + CW'(1);
  end

  // timeout is the terminal count; the FSM qualifies it with !mem_ready
  assign timeout = (cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer: drives PC, IR, ALU/flags and data memory
// control, tracks subroutine depth and bounds memory waits.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX   = 15,
  parameter int CALL_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [15:0] ir,
  input  logic [3:0]  ccr,
  output logic [2:0]  pc_op,
  output logic        ir_ld,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        alu_en,
  output logic        ccr_ld,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int DW = $clog2(CALL_DEPTH + 1);

  state_t    cur, nxt;
  op_class_t cls;
  pc_op_t    pc_op_c;
  logic [DW-1:0] depth;
  logic depth_inc, depth_dec, waiting, timeout;
  logic ir_ld_c, mem_rd_c, mem_wr_c, alu_en_c, ccr_ld_c;
  logic unused_bits;

  assign cls = classify(ir[15:8]);
  assign unused_bits = ^{ir[7:0], ccr[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      cur   <= ST_FETCH;
      depth <= '0;
    end else begin
      cur <= nxt;
      if (depth_inc) depth <= depth + DW'(1);
      else if (depth_dec) depth <= depth - DW'(1);
    end
  end

  always_comb begin
    nxt = cur;
    pc_op_c = PC_HOLD;
    ir_ld_c = 1'b0;
    mem_rd_c = 1'b0;
    mem_wr_c = 1'b0;
    alu_en_c = 1'b0;
    ccr_ld_c = 1'b0;
    depth_inc = 1'b0;
    depth_dec = 1'b0;
    waiting = 1'b0;
    case (cur)
      ST_FETCH: if (run) begin
        mem_rd_c = 1'b1;
        waiting  = 1'b1;
        if (mem_ready) begin
          ir_ld_c = 1'b1;
          nxt = ST_DECODE;
        end else if (timeout) nxt = ST_FAULT;
      end
      ST_DECODE: case (cls)
        CL_JZE, CL_JNE, CL_JCY: nxt = ST_COND;
        CL_MER, CL_MEW:         nxt = ST_MEM;
        CL_HLT:                 nxt = ST_HALT;
        default:                nxt = ST_EXEC;
      endcase
      ST_EXEC: begin
        nxt = ST_FETCH;
        case (cls)
          CL_JMP: pc_op_c = PC_JUMP;
          CL_BSR: if (depth < DW'(CALL_DEPTH)) begin
            pc_op_c = PC_CALL;
            depth_inc = 1'b1;
          end else nxt = ST_FAULT;
          CL_RET: if (depth != '0) begin
            pc_op_c = PC_RET;
            depth_dec = 1'b1;
          end else nxt = ST_FAULT;
          default: begin
            alu_en_c = 1'b1;
            ccr_ld_c = 1'b1;
            pc_op_c  = PC_INC;
          end
        endcase
      end
      ST_COND: begin
        nxt = ST_FETCH;
        case (cls)
          CL_JZE:  pc_op_c = ccr[CCR_Z] ? PC_JUMP : PC_INC;
          CL_JNE:  pc_op_c = ccr[CCR_N] ? PC_JUMP : PC_INC;
          default: pc_op_c = ccr[CCR_C] ? PC_JUMP : PC_INC;
        endcase
      end
      ST_MEM: begin
        mem_rd_c = (cls == CL_MER);
        mem_wr_c = (cls != CL_MER);
        waiting  = 1'b1;
        if (mem_ready) begin
          pc_op_c = PC_INC;
          nxt = ST_FETCH;
        end else if (timeout) nxt = ST_FAULT;
      end
      default: nxt = cur;
    endcase
  end

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!waiting || (nxt != cur)),
    .en      (waiting && !mem_ready),
    .timeout (timeout)
  );

  // reset forces every output low combinationally, not just after the edge
  assign pc_op  = rst ? PC_HOLD : pc_op_c;
  assign ir_ld  = ir_ld_c  & ~rst;
  assign mem_rd = mem_rd_c & ~rst;
  assign mem_wr = mem_wr_c & ~rst;
  assign alu_en = alu_en_c & ~rst;
  assign ccr_ld = ccr_ld_c & ~rst;
  assign halted = (cur == ST_HALT)  & ~rst;
  assign fault  = (cur == ST_FAULT) & ~rst;
  assign state  = rst ? ST_FETCH : cur;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;

  logic        clk, rst, run, mem_ready;
  logic [15:0] ir;
  logic [3:0]  ccr;
  logic [2:0]  pc_op, state;
  logic        ir_ld, mem_rd, mem_wr, alu_en, ccr_ld, halted, fault;

  int tests = 0;
  int fails = 0;

  cpu_sequencer #(.WAIT_MAX(15), .CALL_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready), .ir(ir), .ccr(ccr),
    .pc_op(pc_op), .ir_ld(ir_ld), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .alu_en(alu_en), .ccr_ld(ccr_ld), .halted(halted), .fault(fault), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = 16'h0; ccr = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // FETCH (zero-wait) then DECODE; returns in the third cycle with mem_ready low
  task automatic fetch_decode(input logic [15:0] i);
    ir = i; run = 1'b1; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    #1;
  endtask

  logic [15:0] br_ir  [6] = '{16'h9040, 16'h9040, 16'hA040, 16'hA040, 16'hB040, 16'hB040};
  logic [3:0]  br_ccr [6] = '{4'b0100, 4'b1011, 4'b1000, 4'b0111, 4'b0001, 4'b1110};
  logic [2:0]  br_exp [6] = '{3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1};

  initial begin
    // outputs held low while rst=1 even with run/mem_ready high
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; ir = 16'h1234; ccr = 4'h0;
    tick();
    tick();
    #1;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_mem_rd", 16'(mem_rd), 16'd0);
    chk("rst_ir_ld", 16'(ir_ld), 16'd0);
    chk("rst_flags", 16'({halted, fault}), 16'd0);

    // ALU 0x1234: FETCH -> DECODE -> EXEC -> FETCH
    do_reset();
    ir = 16'h1234; run = 1'b1; mem_ready = 1'b1;
    #1;
    chk("alu_c1_state", 16'(state), 16'd0);
    chk("alu_c1_rd_ld", 16'({mem_rd, ir_ld}), 16'b11);
    chk("alu_c1_pc", 16'(pc_op), 16'd0);
    tick();
    run = 1'b0; mem_ready = 1'b0;
    #1;
    chk("alu_c2_state", 16'(state), 16'd1);
    chk("alu_c2_outs", 16'({pc_op, mem_rd, ir_ld, alu_en, ccr_ld}), 16'd0);
    tick();
    #1;
    chk("alu_c3_state", 16'(state), 16'd2);
    chk("alu_c3_en_ld", 16'({alu_en, ccr_ld}), 16'b11);
    chk("alu_c3_pc", 16'(pc_op), 16'd1);
    tick();
    #1;
    chk("alu_c4_state", 16'(state), 16'd0);
    chk("alu_c4_norun_rd", 16'(mem_rd), 16'd0);

    // conditional branches
    for (int k = 0; k < 6; k++) begin
      do_reset();
      ccr = br_ccr[k];
      fetch_decode(br_ir[k]);
      chk("br_state", 16'(state), 16'd3);
      chk("br_pc", 16'(pc_op), 16'(br_exp[k]));
      tick();
      #1;
      chk("br_back", 16'(state), 16'd0);
    end

    // JMP
    do_reset();
    fetch_decode(16'h8123);
    chk("jmp_pc", 16'(pc_op), 16'd2);
    chk("jmp_alu", 16'(alu_en), 16'd0);

    // four nested BSR then overflow fault
    do_reset();
    for (int k = 0; k < 4; k++) begin
      fetch_decode(16'hE005);
      chk("bsr_pc", 16'(pc_op), 16'd3);
      tick();
      #1;
    end
    fetch_decode(16'hE005);
    chk("bsr5_pc", 16'(pc_op), 16'd0);
    tick();
    #1;
    chk("bsr5_fault", 16'(fault), 16'd1);
    chk("bsr5_state", 16'(state), 16'd6);

    // BSR, RET, then RET underflow
    do_reset();
    fetch_decode(16'hE005);
    chk("call_pc", 16'(pc_op), 16'd3);
    tick();
    #1;
    fetch_decode(16'h0D00);
    chk("ret_pc", 16'(pc_op), 16'd4);
    tick();
    #1;
    fetch_decode(16'h0D00);
    chk("ret0_pc", 16'(pc_op), 16'd0);
    tick();
    #1;
    chk("ret0_fault", 16'({fault, state}), 16'({1'b1, 3'd6}));

    // MER with three wait cycles
    do_reset();
    fetch_decode(16'hC010);
    for (int k = 0; k < 3; k++) begin
      chk("mer_wait", 16'({state, mem_rd, mem_wr, pc_op}), 16'({3'd4, 1'b1, 1'b0, 3'd0}));
      tick();
      #1;
    end
    mem_ready = 1'b1;
    #1;
    chk("mer_done", 16'({mem_rd, pc_op}), 16'({1'b1, 3'd1}));
    run = 1'b0;
    tick();
    #1;
    chk("mer_back", 16'({state, mem_rd}), 16'({3'd0, 1'b0}));

    // MER timeout: 15 non-ready cycles in MEM, then FAULT
    do_reset();
    fetch_decode(16'hC010);
    for (int k = 0; k < 15; k++) begin
      chk("mer_to_wait", 16'({state, mem_rd}), 16'({3'd4, 1'b1}));
      tick();
      #1;
    end
    chk("mer_to_fault", 16'({state, fault, mem_rd}), 16'({3'd6, 1'b1, 1'b0}));

    // FETCH timeout
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk("fetch_to_wait", 16'({state, mem_rd}), 16'({3'd0, 1'b1}));
      tick();
    end
    #1;
    chk("fetch_to_fault", 16'(fault), 16'd1);

    // HLT sticks regardless of run
    do_reset();
    fetch_decode(16'h0F00);
    for (int k = 0; k < 20; k++) begin
      chk("hlt", 16'({halted, state, pc_op, mem_rd}), 16'({1'b1, 3'd5, 3'd0, 1'b0}));
      run = k[0];
      mem_ready = 1'b1;
      tick();
      #1;
    end
    rst = 1'b1;
    #1;
    chk("hlt_rst_comb", 16'({halted, state}), 16'd0);
    tick();
    rst = 1'b0; run = 1'b0;
    #1;
    chk("hlt_rst_after", 16'({halted, fault, state, mem_rd, pc_op}), 16'd0);

    // reset during a MEW wait
    do_reset();
    fetch_decode(16'hD020);
    chk("mew_wr", 16'({mem_wr, mem_rd, state}), 16'({1'b1, 1'b0, 3'd4}));
    tick();
    #1;
    chk("mew_wr2", 16'(mem_wr), 16'd1);
    rst = 1'b1;
    tick();
    #1;
    chk("mew_rst", 16'({mem_wr, state}), 16'd0);
    rst = 1'b0; run = 1'b0; mem_ready = 1'b1;
    #1;
    chk("norun_fetch", 16'({mem_rd, ir_ld, state}), 16'd0);
    tick();
    #1;
    chk("norun_stay", 16'({mem_rd, state}), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
